// File: rtl/plot_pixel_feeder.sv
// Streams the 1-bit bitmap from the frame BRAM to the plotter, one pixel per ready handshake, serpentine scan.
// Latency: pixel presented RD_LAT+2 cycles after a fetch starts; done_out pulses in the cycle after the last consume.
// Backpressure: a pixel is held until a ready rising edge (or one edge remembered while fetching); extra edges are dropped.
module plot_pixel_feeder #(
  parameter int WIDTH      = 80,
  parameter int HEIGHT     = 106,
  parameter int ADDR_W     = 17,
  parameter int RD_LAT     = 2,
  parameter int SERPENTINE = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              ready_in,
  input  logic              bram_data_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic              pixel_value_out,
  output logic              pixel_valid_out,
  output logic [6:0]        col_out,
  output logic [6:0]        row_out,
  output logic              busy_out,
  output logic              done_out
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, PRESENT, DONE} state_t;

  localparam int         CNT_W    = $clog2(RD_LAT + 1) + 1;
  localparam logic [6:0] LAST_COL = 7'(WIDTH - 1);
  localparam logic [6:0] LAST_ROW = 7'(HEIGHT - 1);

  state_t             state;
  logic               start_q;
  logic               ready_q;
  logic               pending;
  logic [CNT_W-1:0]   rd_cnt;

  logic               start_rise;
  logic               rdy_rise;
  logic               consume;
  logic               odd_rev;
  logic               at_row_end;
  logic               last_pix;
  logic [ADDR_W-1:0]  pix_addr;

  assign start_rise = start_in & ~start_q;
  assign rdy_rise   = ready_in & ~ready_q;
  assign consume    = rdy_rise | pending;

  // Odd rows run right-to-left only in serpentine mode.
  assign odd_rev    = (SERPENTINE != 0) && row_out[0];
  assign at_row_end = odd_rev ? (col_out == 7'd0) : (col_out == LAST_COL);
  assign last_pix   = (row_out == LAST_ROW) && at_row_end;
  assign pix_addr   = ADDR_W'(row_out) * ADDR_W'(WIDTH) + ADDR_W'(col_out);

  // Edge-detect registers for start and ready.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      start_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      start_q <= start_in;
      ready_q <= ready_in;
    end
  end

  // Scan FSM: fetch, wait out BRAM latency, present, advance or finish.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      bram_addr_out   <= '0;
      pixel_value_out <= 1'b0;
      pixel_valid_out <= 1'b0;
      col_out         <= '0;
      row_out         <= '0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      pending         <= 1'b0;
      rd_cnt          <= '0;
    end else begin
      done_out <= 1'b0;
      if (state != IDLE && state != DONE && !start_in) begin
        // Start dropped mid-drawing: abandon silently, no done pulse.
        state           <= IDLE;
        busy_out        <= 1'b0;
        pixel_valid_out <= 1'b0;
        pending         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise) begin
              row_out  <= '0;
              col_out  <= '0;
              busy_out <= 1'b1;
              pending  <= 1'b0;
              state    <= FETCH;
            end
          end
          FETCH: begin
            bram_addr_out <= pix_addr;
            rd_cnt        <= '0;
            if (rdy_rise) pending <= 1'b1;
            state <= WAIT_RD;
          end
          WAIT_RD: begin
            if (rdy_rise) pending <= 1'b1;
            if (rd_cnt == CNT_W'(RD_LAT)) begin
              pixel_value_out <= bram_data_in;
              pixel_valid_out <= 1'b1;
              state           <= PRESENT;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
          PRESENT: begin
            if (consume) begin
              pending         <= 1'b0;
              pixel_valid_out <= 1'b0;
              if (last_pix) begin
                done_out <= 1'b1;
                state    <= DONE;
              end else begin
                if (odd_rev) begin
                  if (col_out == 7'd0) row_out <= row_out + 1'b1;
                  else                 col_out <= col_out - 1'b1;
                end else if (col_out == LAST_COL) begin
                  row_out <= row_out + 1'b1;
                  if (SERPENTINE == 0) col_out <= '0;
                end else begin
                  col_out <= col_out + 1'b1;
                end
                state <= FETCH;
              end
            end
          end
          DONE: begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plot_pixel_feeder.sv
// Bench for plot_pixel_feeder: full serpentine drawing with random ready, handshake corners, abort, raster config.
// Latency: n/a (testbench).
// Backpressure: ready driven from tables, hand sequences and $urandom.
module tb_plot_pixel_feeder;

  localparam int W  = 80;
  localparam int H  = 106;
  localparam int N  = W * H;
  localparam int SN = 12;

  logic        clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in, start_in, ready_in, bram_data_in;
  logic [16:0] bram_addr_out;
  logic        pixel_value_out, pixel_valid_out, busy_out, done_out;
  logic [6:0]  col_out, row_out;

  logic        start_s, ready_s, data_s;
  logic [16:0] addr_s;
  logic        val_s, vld_s, busy_s, done_s;
  logic [6:0]  col_s, row_s;

  plot_pixel_feeder #(.WIDTH(W), .HEIGHT(H), .ADDR_W(17), .RD_LAT(2), .SERPENTINE(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .ready_in(ready_in),
    .bram_data_in(bram_data_in), .bram_addr_out(bram_addr_out),
    .pixel_value_out(pixel_value_out), .pixel_valid_out(pixel_valid_out),
    .col_out(col_out), .row_out(row_out), .busy_out(busy_out), .done_out(done_out));

  plot_pixel_feeder #(.WIDTH(4), .HEIGHT(3), .ADDR_W(17), .RD_LAT(2), .SERPENTINE(0)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_s), .ready_in(ready_s),
    .bram_data_in(data_s), .bram_addr_out(addr_s),
    .pixel_value_out(val_s), .pixel_valid_out(vld_s),
    .col_out(col_s), .row_out(row_s), .busy_out(busy_s), .done_out(done_s));

  // Two-stage BRAM models: data appears two cycles after the address.
  logic mem   [N];
  logic mem_s [SN];
  logic rd1, rd1_s;
  always @(posedge clk_in) begin
    rd1          <= mem[bram_addr_out];
    bram_data_in <= rd1;
    rd1_s        <= mem_s[addr_s];
    data_s       <= rd1_s;
  end

  int n_tests = 0;
  int n_fail  = 0;

  int mon_idx, done_cnt, done_at;
  bit prev_vld;
  int obs_addr [N];

  int          s_idx, s_done;
  bit          s_prev;
  logic [16:0] s_addr [SN];
  logic        s_val  [SN];
  logic [6:0]  s_row  [SN];
  logic [6:0]  s_col  [SN];

  typedef struct {
    logic val;
    int   addr;
    int   row;
    int   col;
  } vec_t;
  vec_t tbl [SN];

  typedef struct {
    int idx;
    int addr;
  } key_t;
  key_t keys [7];

  task automatic chk(input string name, input bit ok, input string got, input string want);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, required %s", name, got, want);
    end
  endtask

  // Reference scan order from plain arithmetic: row-major, odd rows reversed when serpentine.
  function automatic int exp_addr(input int idx, input int w, input bit serp);
    int r, k, c;
    r = idx / w;
    k = idx % w;
    c = (serp && (r % 2 == 1)) ? (w - 1 - k) : k;
    return r * w + c;
  endfunction

  // Advance one cycle, then observe both DUTs away from the edge.
  task automatic tick();
    int e;
    @(posedge clk_in);
    #1;
    if (pixel_valid_out && !prev_vld) begin
      if (mon_idx < N) begin
        e = exp_addr(mon_idx, W, 1'b1);
        obs_addr[mon_idx] = int'(bram_addr_out);
        chk("pixel",
            bram_addr_out == 17'(e) && pixel_value_out == mem[e] &&
            row_out == 7'(e / W) && col_out == 7'(e % W),
            $sformatf("idx %0d addr %0d val %0b row %0d col %0d", mon_idx,
                      bram_addr_out, pixel_value_out, row_out, col_out),
            $sformatf("addr %0d val %0b row %0d col %0d", e, mem[e], e / W, e % W));
      end else begin
        chk("pixel_overrun", 1'b0, $sformatf("idx %0d", mon_idx), $sformatf("< %0d", N));
      end
      mon_idx++;
    end
    prev_vld = pixel_valid_out;
    if (done_out) begin
      done_cnt++;
      done_at = mon_idx;
    end
    if (vld_s && !s_prev) begin
      if (s_idx < SN) begin
        s_addr[s_idx] = addr_s;
        s_val[s_idx]  = val_s;
        s_row[s_idx]  = row_s;
        s_col[s_idx]  = col_s;
      end
      s_idx++;
    end
    s_prev = vld_s;
    if (done_s) s_done++;
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!pixel_valid_out && t < 30) begin
      tick();
      t++;
    end
    chk(name, pixel_valid_out, "no pixel presented", "pixel_valid_out=1 within 30 cycles");
  endtask

  initial begin
    int cyc, n, d0;
    logic [11:0] pat;

    for (int i = 0; i < N; i++) mem[i] = 1'($urandom_range(0, 1));
    pat = 12'hA5A;
    for (int i = 0; i < SN; i++) mem_s[i] = pat[11-i];

    // Raster 4x3: addresses in order, data 0xA5A MSB first.
    tbl[0]  = '{1'b1, 0,  0, 0};
    tbl[1]  = '{1'b0, 1,  0, 1};
    tbl[2]  = '{1'b1, 2,  0, 2};
    tbl[3]  = '{1'b0, 3,  0, 3};
    tbl[4]  = '{1'b0, 4,  1, 0};
    tbl[5]  = '{1'b1, 5,  1, 1};
    tbl[6]  = '{1'b0, 6,  1, 2};
    tbl[7]  = '{1'b1, 7,  1, 3};
    tbl[8]  = '{1'b1, 8,  2, 0};
    tbl[9]  = '{1'b0, 9,  2, 1};
    tbl[10] = '{1'b1, 10, 2, 2};
    tbl[11] = '{1'b0, 11, 2, 3};

    // Serpentine boundary addresses for the 80x106 drawing.
    keys[0] = '{0, 0};
    keys[1] = '{1, 1};
    keys[2] = '{79, 79};
    keys[3] = '{80, 159};
    keys[4] = '{159, 80};
    keys[5] = '{160, 160};
    keys[6] = '{8479, 8400};

    mon_idx = 0; done_cnt = 0; done_at = -1; prev_vld = 1'b0;
    s_idx = 0; s_done = 0; s_prev = 1'b0;

    rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b0; start_s = 1'b0; ready_s = 1'b0;
    repeat (3) tick();
    chk("reset_state",
        bram_addr_out == 0 && !pixel_value_out && !pixel_valid_out && col_out == 0 &&
        row_out == 0 && !busy_out && !done_out,
        $sformatf("addr %0d val %0b vld %0b col %0d row %0d busy %0b done %0b", bram_addr_out,
                  pixel_value_out, pixel_valid_out, col_out, row_out, busy_out, done_out),
        "all zero");
    chk("reset_state_s", addr_s == 0 && !vld_s && !busy_s && !done_s,
        $sformatf("addr %0d vld %0b busy %0b done %0b", addr_s, vld_s, busy_s, done_s), "all zero");

    // Reset asserted for three cycles while a pixel is presented.
    rst_in = 1'b0;
    mon_idx = 0;
    start_in = 1'b1;
    wait_valid("t1_present");
    repeat (2) tick();
    rst_in = 1'b1; start_in = 1'b0; d0 = done_cnt;
    repeat (3) tick();
    chk("t1_reset_outputs",
        bram_addr_out == 0 && !pixel_value_out && !pixel_valid_out && col_out == 0 &&
        row_out == 0 && !busy_out && !done_out,
        $sformatf("addr %0d vld %0b col %0d row %0d busy %0b", bram_addr_out, pixel_valid_out,
                  col_out, row_out, busy_out), "all zero");
    rst_in = 1'b0;
    repeat (5) tick();
    chk("t1_idle_after_reset", !busy_out && !pixel_valid_out && done_cnt == d0,
        $sformatf("busy %0b vld %0b dones %0d", busy_out, pixel_valid_out, done_cnt - d0),
        "busy 0 vld 0 dones 0");

    // Ready held high: exactly one pixel per rising edge.
    mon_idx = 0;
    start_in = 1'b1;
    wait_valid("t3_first");
    ready_in = 1'b1;
    repeat (40) tick();
    chk("t3_held_high", mon_idx == 2 && pixel_valid_out,
        $sformatf("presented %0d vld %0b", mon_idx, pixel_valid_out), "presented 2 vld 1");
    ready_in = 1'b0;
    tick();
    ready_in = 1'b1;
    repeat (10) tick();
    chk("t3_second_edge", mon_idx == 3 && pixel_valid_out,
        $sformatf("presented %0d vld %0b", mon_idx, pixel_valid_out), "presented 3 vld 1");
    ready_in = 1'b0;
    tick();

    // Edge during the read wait is remembered once; a second edge there is dropped.
    n = mon_idx;
    ready_in = 1'b1; tick();
    ready_in = 1'b0; tick();
    ready_in = 1'b1; tick();
    ready_in = 1'b0; tick();
    ready_in = 1'b1; tick();
    ready_in = 1'b0;
    repeat (30) tick();
    chk("t4_pending_one_deep", mon_idx == n + 2 && pixel_valid_out,
        $sformatf("presented %0d vld %0b", mon_idx - n, pixel_valid_out), "presented 2 vld 1");
    start_in = 1'b0;
    tick();
    chk("t4_abort", !busy_out && !pixel_valid_out,
        $sformatf("busy %0b vld %0b", busy_out, pixel_valid_out), "busy 0 vld 0");

    // Full drawing with random ready pattern.
    tick();
    mon_idx = 0; done_cnt = 0; done_at = -1;
    start_in = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < 75000) begin
      ready_in = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("t2_done_seen", done_cnt == 1, $sformatf("%0d pulses after %0d cycles", done_cnt, cyc),
        "1 pulse within 75000 cycles");
    chk("t2_pixel_count", mon_idx == N, $sformatf("%0d", mon_idx), $sformatf("%0d", N));
    chk("t2_done_after_last", done_at == N, $sformatf("at pixel %0d", done_at),
        $sformatf("at pixel %0d", N));
    ready_in = 1'b0;
    repeat (5) tick();
    chk("t2_single_done_idle", done_cnt == 1 && !busy_out,
        $sformatf("pulses %0d busy %0b", done_cnt, busy_out), "pulses 1 busy 0");
    for (int i = 0; i < 7; i++)
      chk($sformatf("t2_key_addr_%0d", keys[i].idx), obs_addr[keys[i].idx] == keys[i].addr,
          $sformatf("%0d", obs_addr[keys[i].idx]), $sformatf("%0d", keys[i].addr));

    // Abort at pixel 500, then restart from the top.
    start_in = 1'b0;
    tick();
    mon_idx = 0; d0 = done_cnt;
    start_in = 1'b1;
    cyc = 0;
    while (mon_idx < 500 && cyc < 10000) begin
      ready_in = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("t5_reach_500", mon_idx >= 500, $sformatf("%0d", mon_idx), ">= 500");
    start_in = 1'b0;
    tick();
    chk("t5_abort_busy", !busy_out && !pixel_valid_out,
        $sformatf("busy %0b vld %0b", busy_out, pixel_valid_out), "busy 0 vld 0");
    ready_in = 1'b0;
    repeat (10) tick();
    chk("t5_no_done", done_cnt == d0, $sformatf("%0d pulses", done_cnt - d0), "0 pulses");
    mon_idx = 0;
    start_in = 1'b1;
    wait_valid("t5_restart_present");
    chk("t5_restart_addr0", bram_addr_out == 0 && row_out == 0 && col_out == 0,
        $sformatf("addr %0d row %0d col %0d", bram_addr_out, row_out, col_out), "addr 0 row 0 col 0");

    // Raster configuration, 4x3.
    start_s = 1'b1;
    cyc = 0;
    while (s_done == 0 && cyc < 500) begin
      ready_s = ~ready_s;
      tick();
      cyc++;
    end
    tick();
    chk("t6_done", s_done == 1, $sformatf("%0d pulses", s_done), "1 pulse");
    chk("t6_count", s_idx == SN, $sformatf("%0d", s_idx), $sformatf("%0d", SN));
    for (int i = 0; i < SN; i++)
      chk($sformatf("t6_vec_%0d", i),
          s_addr[i] == 17'(tbl[i].addr) && s_val[i] == tbl[i].val &&
          s_row[i] == 7'(tbl[i].row) && s_col[i] == 7'(tbl[i].col),
          $sformatf("addr %0d val %0b row %0d col %0d", s_addr[i], s_val[i], s_row[i], s_col[i]),
          $sformatf("addr %0d val %0b row %0d col %0d", tbl[i].addr, tbl[i].val, tbl[i].row,
                    tbl[i].col));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
